fadd_stream_acc: RTL and testbench

- Sequential front/back end for the combinational single-precision adder (FADD_1).
- Accepts a valid/ready stream of IEEE-754 binary32 operands, drives the adder's A/B inputs from registered values and captures its X result.
- Emits the running sum when the element flagged last has been accumulated.
- The adder is instantiated outside this block and connected through the add_* ports, so one adder can be shared or swapped.

---
 rtl/fadd_stream_acc.sv | 113 +++++++++++
 tb/tb_fadd_stream_acc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fadd_stream_acc.sv
// Streaming accumulator around an external combinational binary32 adder.
// Sums a valid/ready stream of operands and emits the total plus element count at the last element.
module fadd_stream_acc #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_x
);

    typedef enum logic [1:0] {S_IN, S_ADD, S_OUT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [31:0]      r_acc;
    logic [31:0]      r_op;
    logic [CNT_W-1:0] r_cnt;
    logic             r_first;
    logic             r_last;
    logic             w_in_hs;
    logic             w_out_hs;
    logic [CNT_W-1:0] w_cnt_inc;

    // Counter holds at all-ones while accumulation continues.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_in_hs     = 1'b0;
        w_out_hs    = 1'b0;
        case (r_state)
            S_IN: begin
                in_ready = 1'b1;
                w_in_hs  = in_valid;
                if (in_valid) begin
                    if (r_first) begin
                        w_state_nxt = in_last ? S_OUT : S_IN;
                    end else begin
                        w_state_nxt = S_ADD;
                    end
                end
            end
            S_ADD: begin
                w_state_nxt = r_last ? S_OUT : S_IN;
            end
            S_OUT: begin
                out_valid = 1'b1;
                w_out_hs  = out_ready;
                if (out_ready) begin
                    w_state_nxt = S_IN;
                end
            end
            default: begin
                w_state_nxt = S_IN;
            end
        endcase
    end

    // The first element bypasses the adder, since +0 cannot seed it exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc   <= 32'h0;
            r_op    <= 32'h0;
            r_cnt   <= '0;
            r_first <= 1'b1;
            r_last  <= 1'b0;
        end else if (w_in_hs) begin
            if (r_first) begin
                r_acc   <= in_data;
                r_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                r_first <= 1'b0;
            end else begin
                r_op   <= in_data;
                r_last <= in_last;
                r_cnt  <= w_cnt_inc;
            end
        end else if (r_state == S_ADD) begin
            r_acc <= add_x;
        end else if (w_out_hs) begin
            r_acc   <= 32'h0;
            r_cnt   <= '0;
            r_first <= 1'b1;
            r_last  <= 1'b0;
        end
    end

    // Adder inputs come straight from registers so they never follow in_data.
    assign add_a     = r_acc;
    assign add_b     = r_op;
    assign out_data  = r_acc;
    assign out_count = r_cnt;

endmodule

// File: tb/tb_fadd_stream_acc.sv
// Bench for fadd_stream_acc: directed sums plus random half-integer streams checked
// against a real-valued reference sum; the external adder is a behavioural model.
module tb_fadd_stream_acc;

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_x;

    int checks = 0;
    int errors = 0;

    fadd_stream_acc #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
        .add_a(add_a), .add_b(add_b), .add_x(add_x)
    );

    always #5 clk = ~clk;

    // binary32 <-> real for normal numbers and zero (enough for exact small sums)
    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        real         a;
        int          e;
        logic [7:0]  ex;
        logic [22:0] fr;
        if (r == 0.0) return 32'h0;
        a = (r < 0.0) ? -r : r;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0)  begin a = a * 2.0; e--; end
        ex = 8'(e);
        fr = 23'($rtoi((a - 1.0) * 8388608.0));
        return {(r < 0.0), ex, fr};
    endfunction

    always_comb add_x = r2f(f2r(add_a) + f2r(add_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_data = $urandom;
            in_last = 1'($urandom);
            tick();
        end
    endtask

    // Offer one element; garbage is driven on in_data while the block is not ready.
    task automatic send(input logic [31:0] d, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_last  = l;
        in_data  = in_ready ? d : $urandom;
        while (in_ready !== 1'b1 && t < 50) begin
            tick();
            t++;
            in_data = in_ready ? d : $urandom;
        end
        if (t >= 50) chk("send_timeout", 32'(t), 32'd0);
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom);
    endtask

    // Called one step after the last handshake edge.
    task automatic recv(input string tag, input logic [31:0] ed, input logic [CNT_W-1:0] ec,
                        input int elat, input int hold);
        int lat = 1;
        while (out_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (elat > 0) chk({tag, "_latency"}, 32'(lat), 32'(elat));
        for (int k = 0; k < hold; k++) begin
            chk({tag, "_hold_data"}, out_data, ed);
            chk({tag, "_hold_cnt"}, 32'(out_count), 32'(ec));
            chk({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        chk({tag, "_data"}, out_data, ed);
        chk({tag, "_cnt"}, 32'(out_count), 32'(ec));
        chk({tag, "_inrdy_busy"}, 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_inrdy_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int          n;
        real         sum;
        logic [31:0] v;
        logic [31:0] exp_d;
        int          exp_c;

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h3F800000;
        in_last   = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_add_a", add_a, 32'h0);
        chk("rst_add_b", add_b, 32'h0);

        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b1);
        recv("one_plus_two", 32'h40400000, 3'd2, 2, 0);

        send(32'h40490FDB, 1'b1);
        recv("single_pi", 32'h40490FDB, 3'd1, 1, 0);

        send(32'h3FC00000, 1'b0);
        send(32'hBFC00000, 1'b1);
        recv("cancel", 32'h00000000, 3'd2, 2, 0);

        for (int i = 0; i < 4; i++) send(32'h3F800000, (i == 3));
        recv("backpressure", 32'h40800000, 3'd4, 2, 5);

        for (int i = 0; i < 3; i++) begin
            send(32'h3F800000, (i == 2));
            if (i < 2) idle($urandom_range(0, 3));
        end
        recv("gaps", 32'h40400000, 3'd3, 2, 0);

        for (int i = 0; i < 9; i++) send(32'h3F800000, (i == 8));
        recv("saturate", 32'h41100000, CNT_MAX, 2, 1);

        send(32'h3F800000, 1'b0);
        send(32'h40000000, 1'b1);
        rst_n = 1'b0;
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", out_data, 32'h0);
        send(32'h40000000, 1'b1);
        recv("after_rst", 32'h40000000, 3'd1, 1, 0);

        for (int s = 0; s < 20; s++) begin
            n   = $urandom_range(1, 6);
            sum = 0.0;
            for (int i = 0; i < n; i++) begin
                v = r2f(real'(int'($urandom_range(0, 64)) - 32) / 2.0);
                if (i == 0 && v == 32'h0) v = 32'h3F000000;
                sum = sum + f2r(v);
                send(v, (i == n - 1));
                if (i < n - 1) idle($urandom_range(0, 3));
            end
            exp_d = (n == 1) ? v : r2f(sum);
            exp_c = (n > int'(CNT_MAX)) ? int'(CNT_MAX) : n;
            recv("random", exp_d, CNT_W'(exp_c), (n == 1) ? 1 : 2, $urandom_range(0, 3));
            idle($urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
